// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Arbitrates between an instruction-fetch requester and a
//                load/store requester for access to a program RAM and a
//                variable RAM. One transaction at a time.
//                FSM: IDLE -> ACCESS -> [WAIT] -> RESP -> IDLE.
//                Round-robin arbitration when both requesters ask at once.
//  Ports       : clk, rst_n (sync, active-low)
//                fetch_req/fetch_address -> fetch_ack/fetch_data
//                ls_req/ls_op/ls_address/ls_wdata/program_counter
//                    -> ls_ack/ls_rdata/ls_error
//                p_ram_* / v_ram_* : single-port RAM interfaces
//                                    (rw 1 = write, 0 = read)
//                busy              : high whenever the FSM is not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int RAM_LATENCY   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_req,
    input  logic [ADDRESS_WIDTH-1:0] fetch_address,
    output logic                     fetch_ack,
    output logic [DATA_WIDTH-1:0]    fetch_data,
    input  logic                     ls_req,
    input  logic [2:0]               ls_op,
    input  logic [ADDRESS_WIDTH-1:0] ls_address,
    input  logic [DATA_WIDTH-1:0]    ls_wdata,
    input  logic [ADDRESS_WIDTH-1:0] program_counter,
    output logic                     ls_ack,
    output logic [DATA_WIDTH-1:0]    ls_rdata,
    output logic                     ls_error,
    output logic                     p_ram_en,
    output logic                     p_ram_rw,
    output logic [ADDRESS_WIDTH-1:0] p_ram_address,
    output logic [DATA_WIDTH-1:0]    p_ram_wdata,
    input  logic [DATA_WIDTH-1:0]    p_ram_rdata,
    output logic                     v_ram_en,
    output logic                     v_ram_rw,
    output logic [ADDRESS_WIDTH-1:0] v_ram_address,
    output logic [DATA_WIDTH-1:0]    v_ram_wdata,
    input  logic [DATA_WIDTH-1:0]    v_ram_rdata,
    output logic                     busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [2:0] c_op_load   = 3'd1;
    localparam logic [2:0] c_op_store  = 3'd2;
    localparam logic [2:0] c_op_loadv  = 3'd3;
    localparam logic [2:0] c_op_storev = 3'd4;
    localparam logic [2:0] c_op_peek   = 3'd5;

    localparam logic [3:0]               c_wait_init = 4'(RAM_LATENCY - 1);
    localparam logic [ADDRESS_WIDTH-1:0] c_addr_one  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]               r_state;
    logic                     r_last_grant;   // 1 = last grant went to load/store
    logic                     r_grant_ls;
    logic                     r_write;
    logic                     r_vram;
    logic [3:0]               r_wait_cnt;
    logic                     r_fetch_ack;
    logic [DATA_WIDTH-1:0]    r_fetch_data;
    logic                     r_ls_ack;
    logic [DATA_WIDTH-1:0]    r_ls_rdata;
    logic                     r_ls_error;
    logic                     r_p_en;
    logic                     r_p_rw;
    logic [ADDRESS_WIDTH-1:0] r_p_address;
    logic [DATA_WIDTH-1:0]    r_p_wdata;
    logic                     r_v_en;
    logic                     r_v_rw;
    logic [ADDRESS_WIDTH-1:0] r_v_address;
    logic [DATA_WIDTH-1:0]    r_v_wdata;

    // On a tie, load/store wins unless it was the last one served.
    logic                     w_grant_ls;
    logic                     w_grant_fetch;
    logic                     w_ls_valid;
    logic                     w_ls_write;
    logic                     w_ls_vram;
    logic [ADDRESS_WIDTH-1:0] w_ls_addr;

    assign w_grant_ls    = ls_req && (!fetch_req || !r_last_grant);
    assign w_grant_fetch = fetch_req && !w_grant_ls;
    assign w_ls_valid    = (ls_op >= c_op_load) && (ls_op <= c_op_peek);
    assign w_ls_write    = (ls_op == c_op_store) || (ls_op == c_op_storev);
    assign w_ls_vram     = (ls_op == c_op_loadv) || (ls_op == c_op_storev);
    // PEEK reads the word after the PC; the add wraps naturally at the width.
    assign w_ls_addr     = (ls_op == c_op_peek) ? (program_counter + c_addr_one) : ls_address;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b0;
            r_grant_ls   <= 1'b0;
            r_write      <= 1'b0;
            r_vram       <= 1'b0;
            r_wait_cnt   <= 4'd0;
            r_fetch_ack  <= 1'b0;
            r_fetch_data <= '0;
            r_ls_ack     <= 1'b0;
            r_ls_rdata   <= '0;
            r_ls_error   <= 1'b0;
            r_p_en       <= 1'b0;
            r_p_rw       <= 1'b0;
            r_p_address  <= '0;
            r_p_wdata    <= '0;
            r_v_en       <= 1'b0;
            r_v_rw       <= 1'b0;
            r_v_address  <= '0;
            r_v_wdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ls || w_grant_fetch) begin
                        r_grant_ls   <= w_grant_ls;
                        r_last_grant <= w_grant_ls;
                        if (w_grant_ls && !w_ls_valid) begin
                            // Invalid op: answer straight away, no RAM touched.
                            r_state    <= S_RESP;
                            r_ls_ack   <= 1'b1;
                            r_ls_error <= 1'b1;
                            r_ls_rdata <= '0;
                        end else begin
                            // RAM strobes are registered here so they are
                            // high for exactly the ACCESS cycle.
                            r_state <= S_ACCESS;
                            if (w_grant_ls) begin
                                r_write <= w_ls_write;
                                r_vram  <= w_ls_vram;
                                if (w_ls_vram) begin
                                    r_v_en      <= 1'b1;
                                    r_v_rw      <= w_ls_write;
                                    r_v_address <= w_ls_addr;
                                    r_v_wdata   <= w_ls_write ? ls_wdata : '0;
                                end else begin
                                    r_p_en      <= 1'b1;
                                    r_p_rw      <= w_ls_write;
                                    r_p_address <= w_ls_addr;
                                    r_p_wdata   <= w_ls_write ? ls_wdata : '0;
                                end
                            end else begin
                                r_write     <= 1'b0;
                                r_vram      <= 1'b0;
                                r_p_en      <= 1'b1;
                                r_p_rw      <= 1'b0;
                                r_p_address <= fetch_address;
                                r_p_wdata   <= '0;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    r_p_en      <= 1'b0;
                    r_p_rw      <= 1'b0;
                    r_p_address <= '0;
                    r_p_wdata   <= '0;
                    r_v_en      <= 1'b0;
                    r_v_rw      <= 1'b0;
                    r_v_address <= '0;
                    r_v_wdata   <= '0;
                    if (r_write) begin
                        // Only the load/store side can write.
                        r_state  <= S_RESP;
                        r_ls_ack <= 1'b1;
                    end else begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= c_wait_init;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        if (r_grant_ls) begin
                            r_ls_rdata <= r_vram ? v_ram_rdata : p_ram_rdata;
                            r_ls_ack   <= 1'b1;
                        end else begin
                            r_fetch_data <= p_ram_rdata;
                            r_fetch_ack  <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_fetch_ack <= 1'b0;
                    r_ls_ack    <= 1'b0;
                    r_ls_error  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fetch_ack     = r_fetch_ack;
    assign fetch_data    = r_fetch_data;
    assign ls_ack        = r_ls_ack;
    assign ls_rdata      = r_ls_rdata;
    assign ls_error      = r_ls_error;
    assign p_ram_en      = r_p_en;
    assign p_ram_rw      = r_p_rw;
    assign p_ram_address = r_p_address;
    assign p_ram_wdata   = r_p_wdata;
    assign v_ram_en      = r_v_en;
    assign v_ram_rw      = r_v_rw;
    assign v_ram_address = r_v_address;
    assign v_ram_wdata   = r_v_wdata;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Self-checking bench for memory_arbiter (RAM_LATENCY = 1).
//                Stimulus pushes expected RAM accesses and responses into
//                queues; a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_address = '0;
    logic        fetch_ack;
    logic [15:0] fetch_data;
    logic        ls_req = 1'b0;
    logic [2:0]  ls_op = '0;
    logic [15:0] ls_address = '0;
    logic [15:0] ls_wdata = '0;
    logic [15:0] program_counter = '0;
    logic        ls_ack;
    logic [15:0] ls_rdata;
    logic        ls_error;
    logic        p_ram_en, p_ram_rw, v_ram_en, v_ram_rw, busy;
    logic [15:0] p_ram_address, p_ram_wdata, v_ram_address, v_ram_wdata;
    logic [15:0] p_ram_rdata = '0;
    logic [15:0] v_ram_rdata = '0;

    memory_arbiter #(
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH   (16),
        .RAM_LATENCY  (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .fetch_address  (fetch_address),
        .fetch_ack      (fetch_ack),
        .fetch_data     (fetch_data),
        .ls_req         (ls_req),
        .ls_op          (ls_op),
        .ls_address     (ls_address),
        .ls_wdata       (ls_wdata),
        .program_counter(program_counter),
        .ls_ack         (ls_ack),
        .ls_rdata       (ls_rdata),
        .ls_error       (ls_error),
        .p_ram_en       (p_ram_en),
        .p_ram_rw       (p_ram_rw),
        .p_ram_address  (p_ram_address),
        .p_ram_wdata    (p_ram_wdata),
        .p_ram_rdata    (p_ram_rdata),
        .v_ram_en       (v_ram_en),
        .v_ram_rw       (v_ram_rw),
        .v_ram_address  (v_ram_address),
        .v_ram_wdata    (v_ram_wdata),
        .v_ram_rdata    (v_ram_rdata),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency RAM models.
    logic [15:0] p_mem [0:65535];
    logic [15:0] v_mem [0:65535];
    always @(posedge clk) begin
        if (p_ram_en === 1'b1) begin
            if (p_ram_rw) p_mem[p_ram_address] <= p_ram_wdata;
            else          p_ram_rdata <= p_mem[p_ram_address];
        end
        if (v_ram_en === 1'b1) begin
            if (v_ram_rw) v_mem[v_ram_address] <= v_ram_wdata;
            else          v_ram_rdata <= v_mem[v_ram_address];
        end
    end

    typedef struct {
        logic        is_v;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          cyc;
    } ram_t;

    typedef struct {
        logic        is_ls;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } resp_t;

    ram_t  ram_q [$];
    resp_t resp_q[$];

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        else
            passed++;
    endtask

    task automatic timeout_fail(input string name);
        total++;
        $display("FAIL %s @cycle %0d: ack never arrived", name, cyc);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        ram_t  r;
        resp_t e;
        if (p_ram_en === 1'b1 || v_ram_en === 1'b1) begin
            check("single_ram_en", {63'd0, p_ram_en & v_ram_en}, 64'd0);
            if (ram_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_ram_en @cycle %0d: got p=%b v=%b expected none", cyc, p_ram_en, v_ram_en);
            end else begin
                r = ram_q.pop_front();
                check("ram_cycle", 64'(cyc), 64'(r.cyc));
                check("ram_select_v", {63'd0, v_ram_en}, {63'd0, r.is_v});
                check("ram_rw", {63'd0, r.is_v ? v_ram_rw : p_ram_rw}, {63'd0, r.rw});
                check("ram_address", {48'd0, r.is_v ? v_ram_address : p_ram_address}, {48'd0, r.addr});
                if (r.rw)
                    check("ram_wdata", {48'd0, r.is_v ? v_ram_wdata : p_ram_wdata}, {48'd0, r.wdata});
            end
        end
        if (p_ram_en !== 1'b1)
            check("p_ram_idle_zero", {30'd0, p_ram_rw, p_ram_address, p_ram_wdata}, 64'd0);
        if (v_ram_en !== 1'b1)
            check("v_ram_idle_zero", {30'd0, v_ram_rw, v_ram_address, v_ram_wdata}, 64'd0);
        if (fetch_ack === 1'b1 || ls_ack === 1'b1) begin
            check("one_ack_only", {63'd0, fetch_ack & ls_ack}, 64'd0);
            if (resp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_ack @cycle %0d: got fetch=%b ls=%b expected none", cyc, fetch_ack, ls_ack);
            end else begin
                e = resp_q.pop_front();
                check("ack_cycle", 64'(cyc), 64'(e.cyc));
                check("ack_is_ls", {63'd0, ls_ack}, {63'd0, e.is_ls});
                if (e.is_ls) begin
                    check("ls_rdata", {48'd0, ls_rdata}, {48'd0, e.data});
                    check("ls_error", {63'd0, ls_error}, {63'd0, e.err});
                end else begin
                    check("fetch_data", {48'd0, fetch_data}, {48'd0, e.data});
                end
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ls_ack(input string name);
        bit got = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (n == 0) check({name, "_busy"}, {63'd0, busy}, 64'd1);
            if (ls_ack === 1'b1) begin got = 1; break; end
        end
        if (!got) timeout_fail(name);
        ls_req = 1'b0;
    endtask

    task automatic wait_fetch_ack(input string name);
        bit got = 0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (fetch_ack === 1'b1) begin got = 1; break; end
        end
        if (!got) timeout_fail(name);
        fetch_req = 1'b0;
    endtask

    // Issued in an IDLE cycle; lat is ack cycle minus grant cycle.
    task automatic ls_txn(input string name, input logic [2:0] op, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] pc,
                          input logic exp_ram, input logic exp_v, input logic exp_rw,
                          input logic [15:0] exp_addr, input logic [15:0] exp_rdata,
                          input logic exp_err, input int lat);
        int g;
        g = cyc;
        ls_req = 1'b1; ls_op = op; ls_address = addr; ls_wdata = wdata; program_counter = pc;
        if (exp_ram) ram_q.push_back('{exp_v, exp_rw, exp_addr, wdata, g + 1});
        resp_q.push_back('{1'b1, exp_rdata, exp_err, g + lat});
        wait_ls_ack(name);
        step();
    endtask

    task automatic fetch_txn(input string name, input logic [15:0] addr, input logic [15:0] exp_data);
        int g;
        g = cyc;
        fetch_req = 1'b1; fetch_address = addr;
        ram_q.push_back('{1'b0, 1'b0, addr, 16'h0000, g + 1});
        resp_q.push_back('{1'b0, exp_data, 1'b0, g + 3});
        wait_fetch_ack(name);
        step();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_p_ram"}, {30'd0, p_ram_en, p_ram_rw, p_ram_address, p_ram_wdata}, 64'd0);
        check({name, "_v_ram"}, {30'd0, v_ram_en, v_ram_rw, v_ram_address, v_ram_wdata}, 64'd0);
        check({name, "_resp"}, {28'd0, fetch_ack, fetch_data, ls_ack, ls_rdata, ls_error, busy}, 64'd0);
    endtask

    initial begin
        int g;
        p_mem[16'h0040] = 16'hBEEF;
        p_mem[16'h0000] = 16'h00AA;
        p_mem[16'h0100] = 16'h5A5A;
        p_mem[16'h0042] = 16'h7777;

        // Reset
        rst_n = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;

        // V3: simultaneous requests from reset; load/store wins the first tie.
        g = cyc;
        fetch_req = 1'b1; fetch_address = 16'h0040;
        ls_req = 1'b1; ls_op = 3'd1; ls_address = 16'h0100;
        ram_q.push_back('{1'b0, 1'b0, 16'h0100, 16'h0000, g + 1});
        ram_q.push_back('{1'b0, 1'b0, 16'h0040, 16'h0000, g + 5});
        resp_q.push_back('{1'b1, 16'h5A5A, 1'b0, g + 3});
        resp_q.push_back('{1'b0, 16'hBEEF, 1'b0, g + 7});
        fork
            wait_ls_ack("v3_ls");
            wait_fetch_ack("v3_fetch");
        join
        step();

        // V1: lone fetch
        fetch_txn("v1_fetch", 16'h0040, 16'hBEEF);
        // V2: STOREV
        ls_txn("v2_storev", 3'd4, 16'h0010, 16'h1234, 16'h0000, 1, 1, 1, 16'h0010, 16'h5A5A, 0, 2);
        // STORE then LOAD back through program RAM
        ls_txn("store", 3'd2, 16'h0200, 16'hCAFE, 16'h0000, 1, 0, 1, 16'h0200, 16'h5A5A, 0, 2);
        ls_txn("load", 3'd1, 16'h0200, 16'h0000, 16'h0000, 1, 0, 0, 16'h0200, 16'hCAFE, 0, 3);
        // V4: PEEK wraps 0xFFFF+1 to 0x0000
        ls_txn("v4_peek_wrap", 3'd5, 16'h0999, 16'h0000, 16'hFFFF, 1, 0, 0, 16'h0000, 16'h00AA, 0, 3);
        ls_txn("peek", 3'd5, 16'h0999, 16'h0000, 16'h0041, 1, 0, 0, 16'h0042, 16'h7777, 0, 3);
        // V5: invalid ops
        ls_txn("v5_op6", 3'd6, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 1);
        ls_txn("op0", 3'd0, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 1);

        // V6: reset during WAIT of a LOAD aborts it.
        g = cyc;
        ls_req = 1'b1; ls_op = 3'd1; ls_address = 16'h0100;
        ram_q.push_back('{1'b0, 1'b0, 16'h0100, 16'h0000, g + 1});
        step();                 // ACCESS
        step();                 // WAIT
        check("v6_in_wait_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        ls_req = 1'b0;
        step();
        check_all_zero("v6_after_reset");
        rst_n = 1'b1;
        repeat (2) step();

        // Recovery and output hold
        ls_txn("loadv", 3'd3, 16'h0010, 16'h0000, 16'h0000, 1, 1, 0, 16'h0010, 16'h1234, 0, 3);
        fetch_txn("fetch_after", 16'h0040, 16'hBEEF);
        repeat (3) step();
        check("ls_rdata_hold", {48'd0, ls_rdata}, 64'h1234);
        check("fetch_data_hold", {48'd0, fetch_data}, 64'hBEEF);
        check("ram_q_drained", 64'(ram_q.size()), 64'd0);
        check("resp_q_drained", 64'(resp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
